tec8_datapath: RTL and testbench
================================

// Module: tec8_datapath
// PURPOSE
//   Executes the control word issued by the hardwired controller (cpu) each beat.
//   Holds R0..R3, the 74181-style ALU, C/Z flags, PC, AR, IR, on-chip memory and the W1..W3 beat sequencer.
//   Feeds IR[7:4], C, Z and W[3:1] back to the controller, closing the control/datapath loop.
// PARAMETERS
//   MEM_AW    8     memory address width (depth 2**MEM_AW bytes; data fixed at 8 bits)
//   RESET_PC  8'h00 PC value after reset
// PORTS
//   T3      in   1  clock; all state updates on posedge T3
//   CLR     in   1  synchronous active-high reset
//   START   in   1  start pulse; sampled high at posedge T3 while halted
//   SD      in   8  console switch data, driven to DBUS by SBUS
//   SELCTL,DRW,LPC,PCINC,PCADD,LAR,ARINC,LIR,LDZ,LDC,CIN,M,MEMW,ABUS,SBUS,MBUS,STOP,SHORT,LONG  in 1 each  control word
//   S       in   4  ALU function select
//   SEL     in   4  console register select: SEL[3:2]=A/dest, SEL[1:0]=B
//   W       out  3  one-hot beat (001=W1, 010=W2, 100=W3)
//   IR      out  8  instruction register (IR[7:4] to controller)
//   C, Z    out  1  carry and zero flags
//   RUN     out  1  beat sequencer running
//   PC, AR  out  8  program counter, address register
//   DBUS    out  8  internal data bus value
//   BUS_ERR out  1  more than one of ABUS/SBUS/MBUS asserted this cycle
// BEHAVIOUR
//   Reset (CLR=1 at posedge): W=001, RUN=0, PC=RESET_PC, AR=0, IR=0, C=0, Z=0, R0..R3=0. Memory not cleared.
//   Reset overrides all controls, including mid-beat and simultaneous START.
//   Beats: one beat per T3 cycle.
//   While RUN=1:
//     W1 -> W1 if SHORT, else W2.
//     W2 -> W3 if LONG, else W1.
//     W3 -> W1.
//   Halting: when next beat is W1 and STOP=1, RUN<=0 and W<=001.
//   While RUN=0: W holds 001; START=1 sets RUN<=1 and that cycle executes nothing.
//   All register, flag, PC, AR, IR and memory writes are gated by RUN=1. No writes occur while halted.
//   Operand select:
//     A/dest index = SELCTL ? SEL[3:2] : IR[3:2].
//     B index      = SELCTL ? SEL[1:0] : IR[1:0].
//     Register reads are combinational.
//   ALU: A,B 8-bit; CIN active-low carry-in (CIN=0 adds 1).
//     M=1 (logic): S=1111 F=A; 1010 F=B; 1011 F=A&B; 1110 F=A|B; 0110 F=A^B; 0000 F=~A.
//       All other S give F=A. Carry-out = 0.
//     M=0 (arith, 9-bit): S=1001 F=A+B+~CIN; 0110 F=A+~B+~CIN; 0000 F=A+~CIN.
//       All other S give F=A+~CIN.
//     Carry-out = bit 8 of the 9-bit result. Subtract with CIN=0: carry-out=1 means no borrow.
//   DBUS: MBUS ? MEM[addr] : SBUS ? SD : ABUS ? F : 8'h00. Fixed priority MBUS > SBUS > ABUS.
//     BUS_ERR is combinational and state updates still proceed.
//   Memory address = LIR ? PC : AR. Read is combinational.
//     MEMW: MEM[AR] <= DBUS at posedge.
//   DRW: R[dest] <= DBUS.
//   LDC: C <= carry-out. LDZ: Z <= (F==0). Flags update only when their load signal is high.
//   LIR: IR <= MEM[PC].
//   PC priority LPC > PCADD > PCINC:
//     LPC:   PC <= DBUS.
//     PCADD: PC <= PC + sign-extended IR[3:0].
//     PCINC: PC <= PC+1.
//   AR: LAR (AR<=DBUS) takes priority over ARINC (AR<=AR+1).
//   PC/AR wrap modulo 2**MEM_AW: FF+1 -> 00; PCADD underflow wraps.
//   LIR with PCINC in the same beat: IR captures the old-PC byte, and PC increments.
//   ALU result and flag inputs use register values from before the edge, so DRW with LDZ in one beat is consistent.
// TESTING
//   CLR=1 mid-W2 with LONG=1 -> next cycle W=001, RUN=0, PC=RESET_PC, C=Z=0.
//   RUN: SHORT=0,LONG=1,STOP=0 -> W sequence 001,010,100,001; SHORT=1 -> W stays 001.
//     STOP=1 at end of W2 -> RUN=0 and further cycles W=001 with no writes.
//   R1=8'hFF, R2=8'h01, SELCTL=0, IR=8'h16, S=1001, M=0, CIN=1, ABUS, DRW, LDC, LDZ in W2
//     -> R1=8'h00, C=1, Z=1.
//   R0=5, R1=5, S=0110, M=0, CIN=0, LDC, LDZ, no DRW -> C=1, Z=1, R0 unchanged.
//     R0=3, R1=5 -> C=0, Z=0.
//   PC=8'h10, IR=8'h8E (offset -2), PCADD -> PC=8'h0E. PC=8'hFF, PCINC -> PC=8'h00.
//   Console write: SBUS, LAR with SD=8'h20, then MEMW, ARINC, SBUS with SD=8'hA5
//     -> MEM[20]=A5, AR=21. MBUS and SBUS together -> DBUS=MEM[AR], BUS_ERR=1.

Source files
------------

// File: rtl/tec8_datapath.sv
// TEC-8 datapath: R0..R3, 74181-style ALU, C/Z, PC/AR/IR, memory and W1..W3 beat sequencer driven by one control word per T3.
// State lands on the T3 edge that ends each beat; DBUS/BUS_ERR are combinational; no backpressure, the run stops only via STOP or CLR.
module tec8_datapath #(
    parameter int unsigned MEM_AW   = 8,
    parameter logic [7:0]  RESET_PC = 8'h00
) (
    input  logic       T3,
    input  logic       CLR,
    input  logic       START,
    input  logic [7:0] SD,
    input  logic       SELCTL, DRW, LPC, PCINC, PCADD, LAR, ARINC, LIR, LDZ, LDC,
    input  logic       CIN, M, MEMW, ABUS, SBUS, MBUS, STOP, SHORT, LONG,
    input  logic [3:0] S,
    input  logic [3:0] SEL,
    output logic [2:0] W,
    output logic [7:0] IR,
    output logic       C,
    output logic       Z,
    output logic       RUN,
    output logic [7:0] PC,
    output logic [7:0] AR,
    output logic [7:0] DBUS,
    output logic       BUS_ERR
);

    typedef enum logic [2:0] {
        BEAT_W1 = 3'b001,
        BEAT_W2 = 3'b010,
        BEAT_W3 = 3'b100
    } beat_t;

    localparam logic [8:0] ADDR_SPAN = 9'(1 << MEM_AW);
    localparam logic [7:0] ADDR_MASK = 8'(ADDR_SPAN - 9'd1);

    beat_t      w_q, w_d, w_next;
    logic       run_q, run_d;
    logic [7:0] pc_q, pc_d, ar_q, ar_d, ir_q, ir_d;
    logic       c_q, c_d, z_q, z_d;
    logic [7:0] r_q [4];
    logic [7:0] mem [1 << MEM_AW];

    logic [1:0] a_idx, b_idx;
    logic [7:0] a_val, b_val, alu_f, mem_addr, mem_rd, dbus, pc_rel;
    logic [8:0] alu_res, cin_ext;
    logic [1:0] bus_cnt;

    assign a_idx   = SELCTL ? SEL[3:2] : ir_q[3:2];
    assign b_idx   = SELCTL ? SEL[1:0] : ir_q[1:0];
    assign a_val   = r_q[a_idx];
    assign b_val   = r_q[b_idx];
    assign cin_ext = {8'd0, ~CIN};

    // CIN is active-low: CIN=0 injects +1 into the arithmetic ops.
    always_comb begin
        alu_res = {1'b0, a_val};
        if (M) begin
            case (S)
                4'b1111: alu_res = {1'b0, a_val};
                4'b1010: alu_res = {1'b0, b_val};
                4'b1011: alu_res = {1'b0, a_val & b_val};
                4'b1110: alu_res = {1'b0, a_val | b_val};
                4'b0110: alu_res = {1'b0, a_val ^ b_val};
                4'b0000: alu_res = {1'b0, ~a_val};
                default: alu_res = {1'b0, a_val};
            endcase
        end else begin
            case (S)
                4'b1001: alu_res = {1'b0, a_val} + {1'b0, b_val} + cin_ext;
                4'b0110: alu_res = {1'b0, a_val} + {1'b0, ~b_val} + cin_ext;
                default: alu_res = {1'b0, a_val} + cin_ext;
            endcase
        end
    end

    assign alu_f    = alu_res[7:0];
    assign mem_addr = LIR ? pc_q : ar_q;
    assign mem_rd   = mem[mem_addr[MEM_AW-1:0]];
    assign pc_rel   = {{4{ir_q[3]}}, ir_q[3:0]};

    always_comb begin
        if (MBUS) begin
            dbus = mem_rd;
        end else if (SBUS) begin
            dbus = SD;
        end else if (ABUS) begin
            dbus = alu_f;
        end else begin
            dbus = 8'h00;
        end
    end

    assign bus_cnt = {1'b0, ABUS} + {1'b0, SBUS} + {1'b0, MBUS};
    assign BUS_ERR = (bus_cnt > 2'd1);
    assign DBUS    = dbus;

    always_comb begin
        case (w_q)
            BEAT_W1: w_next = SHORT ? BEAT_W1 : BEAT_W2;
            BEAT_W2: w_next = LONG ? BEAT_W3 : BEAT_W1;
            default: w_next = BEAT_W1;
        endcase
    end

    always_comb begin
        w_d   = w_q;
        run_d = run_q;
        pc_d  = pc_q;
        ar_d  = ar_q;
        ir_d  = ir_q;
        c_d   = c_q;
        z_d   = z_q;
        if (!run_q) begin
            // The START cycle only arms the sequencer; nothing executes.
            w_d = BEAT_W1;
            if (START) begin
                run_d = 1'b1;
            end
        end else begin
            w_d = w_next;
            if (w_next == BEAT_W1 && STOP) begin
                run_d = 1'b0;
            end
            if (LDC) c_d = alu_res[8];
            if (LDZ) z_d = (alu_f == 8'h00);
            if (LIR) ir_d = mem_rd;
            if (LPC) begin
                pc_d = dbus & ADDR_MASK;
            end else if (PCADD) begin
                pc_d = (pc_q + pc_rel) & ADDR_MASK;
            end else if (PCINC) begin
                pc_d = (pc_q + 8'd1) & ADDR_MASK;
            end
            if (LAR) begin
                ar_d = dbus & ADDR_MASK;
            end else if (ARINC) begin
                ar_d = (ar_q + 8'd1) & ADDR_MASK;
            end
        end
    end

    always_ff @(posedge T3) begin
        if (CLR) begin
            w_q   <= BEAT_W1;
            run_q <= 1'b0;
            pc_q  <= RESET_PC;
            ar_q  <= 8'h00;
            ir_q  <= 8'h00;
            c_q   <= 1'b0;
            z_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_q[i] <= 8'h00;
            end
        end else begin
            w_q   <= w_d;
            run_q <= run_d;
            pc_q  <= pc_d;
            ar_q  <= ar_d;
            ir_q  <= ir_d;
            c_q   <= c_d;
            z_q   <= z_d;
            if (run_q && DRW) begin
                r_q[a_idx] <= dbus;
            end
        end
    end

    // Memory contents survive CLR; only the write is suppressed.
    always_ff @(posedge T3) begin
        if (!CLR && run_q && MEMW) begin
            mem[ar_q[MEM_AW-1:0]] <= dbus;
        end
    end

    assign W   = w_q;
    assign RUN = run_q;
    assign PC  = pc_q;
    assign AR  = ar_q;
    assign IR  = ir_q;
    assign C   = c_q;
    assign Z   = z_q;

endmodule

// File: tb/tb_tec8_datapath.sv
// Bench for tec8_datapath: directed console/ALU/PC/beat scenarios plus random control words, scored against a behavioural model.
module tb_tec8_datapath;
    localparam logic [7:0] RST_PC = 8'h00;

    logic       T3 = 1'b0;
    logic       CLR, START, SELCTL, DRW, LPC, PCINC, PCADD, LAR, ARINC, LIR, LDZ, LDC;
    logic       CIN, M, MEMW, ABUS, SBUS, MBUS, STOP, SHORT, LONG;
    logic [7:0] SD;
    logic [3:0] S, SEL;
    logic [2:0] W;
    logic [7:0] IR, PC, AR, DBUS;
    logic       C, Z, RUN, BUS_ERR;

    tec8_datapath #(.MEM_AW(8), .RESET_PC(RST_PC)) dut (
        .T3(T3), .CLR(CLR), .START(START), .SD(SD),
        .SELCTL(SELCTL), .DRW(DRW), .LPC(LPC), .PCINC(PCINC), .PCADD(PCADD), .LAR(LAR),
        .ARINC(ARINC), .LIR(LIR), .LDZ(LDZ), .LDC(LDC), .CIN(CIN), .M(M), .MEMW(MEMW),
        .ABUS(ABUS), .SBUS(SBUS), .MBUS(MBUS), .STOP(STOP), .SHORT(SHORT), .LONG(LONG),
        .S(S), .SEL(SEL), .W(W), .IR(IR), .C(C), .Z(Z), .RUN(RUN), .PC(PC), .AR(AR),
        .DBUS(DBUS), .BUS_ERR(BUS_ERR)
    );

    always #5 T3 = ~T3;

    typedef struct {
        logic clr, start, selctl, drw, lpc, pcinc, pcadd, lar, arinc, lir, ldz, ldc;
        logic cin, m, memw, abus, sbus, mbus, stop, sht, lng;
        logic [7:0] sd;
        logic [3:0] s, sel;
    } ctrl_t;

    typedef struct {
        int w, run, pc, ar, ir, c, z, dbus, err;
    } obs_t;

    // Reference machine state, beat held as 1..3.
    int   m_w = 1, m_pc = 0, m_ar = 0, m_ir = 0, m_c = 0, m_z = 0, m_run = 0;
    int   m_r [4];
    int   m_mem [256];
    obs_t sb [$];
    obs_t mon_e, mon_a;
    int   n_checks = 0, n_pass = 0;

    function automatic ctrl_t nop();
        ctrl_t k = '{default: '0};
        k.cin = 1'b1;
        k.sht = 1'b1;
        return k;
    endfunction

    function automatic void ref_alu(input int a, input int b, input logic [3:0] s, input logic m,
                                    input logic cin, output int f, output int co);
        int ci = cin ? 0 : 1;
        int res;
        if (m) begin
            case (s)
                4'b1010: res = b;
                4'b1011: res = a & b;
                4'b1110: res = a | b;
                4'b0110: res = a ^ b;
                4'b0000: res = 255 - a;
                default: res = a;
            endcase
            co = 0;
        end else begin
            case (s)
                4'b1001: res = a + b + ci;
                4'b0110: res = a + (255 - b) + ci;
                default: res = a + ci;
            endcase
            co = (res > 255) ? 1 : 0;
        end
        f = res % 256;
    endfunction

    function automatic void ref_bus(input ctrl_t k, output int dbus, output int err, output int f, output int co);
        int ai   = k.selctl ? int'(k.sel[3:2]) : (m_ir / 4) % 4;
        int bi   = k.selctl ? int'(k.sel[1:0]) : m_ir % 4;
        int addr = k.lir ? m_pc : m_ar;
        ref_alu(m_r[ai], m_r[bi], k.s, k.m, k.cin, f, co);
        if (k.mbus)      dbus = m_mem[addr];
        else if (k.sbus) dbus = int'(k.sd);
        else if (k.abus) dbus = f;
        else             dbus = 0;
        err = (int'(k.abus) + int'(k.sbus) + int'(k.mbus) > 1) ? 1 : 0;
    endfunction

    task automatic ref_step(input ctrl_t k);
        int dbus, err, f, co, dest, off, nxt, new_ir;
        obs_t e;
        if (k.clr) begin
            m_w = 1; m_run = 0; m_pc = int'(RST_PC); m_ar = 0; m_ir = 0; m_c = 0; m_z = 0;
            for (int i = 0; i < 4; i++) m_r[i] = 0;
        end else if (m_run == 0) begin
            if (k.start) m_run = 1;
            m_w = 1;
        end else begin
            ref_bus(k, dbus, err, f, co);
            dest   = k.selctl ? int'(k.sel[3:2]) : (m_ir / 4) % 4;
            off    = m_ir % 16;
            if (off >= 8) off -= 16;
            new_ir = k.lir ? m_mem[m_pc] : m_ir;
            if (k.memw) m_mem[m_ar] = dbus;
            if (k.drw)  m_r[dest] = dbus;
            if (k.ldc)  m_c = co;
            if (k.ldz)  m_z = (f == 0) ? 1 : 0;
            m_ir = new_ir;
            if (k.lpc)        m_pc = dbus;
            else if (k.pcadd) m_pc = (m_pc + off + 256) % 256;
            else if (k.pcinc) m_pc = (m_pc + 1) % 256;
            if (k.lar)        m_ar = dbus;
            else if (k.arinc) m_ar = (m_ar + 1) % 256;
            case (m_w)
                1:       nxt = k.sht ? 1 : 2;
                2:       nxt = k.lng ? 3 : 1;
                default: nxt = 1;
            endcase
            if (nxt == 1 && k.stop) m_run = 0;
            m_w = nxt;
        end
        ref_bus(k, e.dbus, e.err, f, co);
        e.w = 1 << (m_w - 1); e.run = m_run; e.pc = m_pc; e.ar = m_ar;
        e.ir = m_ir; e.c = m_c; e.z = m_z;
        sb.push_back(e);
    endtask

    task automatic drive(input ctrl_t k);
        CLR = k.clr; START = k.start; SELCTL = k.selctl; DRW = k.drw; LPC = k.lpc; PCINC = k.pcinc;
        PCADD = k.pcadd; LAR = k.lar; ARINC = k.arinc; LIR = k.lir; LDZ = k.ldz; LDC = k.ldc;
        CIN = k.cin; M = k.m; MEMW = k.memw; ABUS = k.abus; SBUS = k.sbus; MBUS = k.mbus;
        STOP = k.stop; SHORT = k.sht; LONG = k.lng; SD = k.sd; S = k.s; SEL = k.sel;
    endtask

    task automatic step(input ctrl_t k);
        @(negedge T3);
        drive(k);
        ref_step(k);
    endtask

    task automatic settle();
        @(posedge T3);
        #2;
    endtask

    task automatic spot(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic con(input logic lpc, input logic lar, input logic drw, input logic memw,
                       input logic [3:0] sel, input logic [7:0] sd);
        ctrl_t k = nop();
        k.sbus = 1'b1; k.lpc = lpc; k.lar = lar; k.drw = drw; k.memw = memw;
        k.selctl = 1'b1; k.sel = sel; k.sd = sd;
        step(k);
    endtask

    task automatic load_ir(input logic [7:0] v);
        ctrl_t k = nop();
        con(0, 1, 0, 0, 4'h0, 8'hF0);
        con(0, 0, 0, 1, 4'h0, v);
        con(1, 0, 0, 0, 4'h0, 8'hF0);
        k.lir = 1'b1;
        step(k);
    endtask

    task automatic read_reg(input logic [1:0] idx);
        ctrl_t k = nop();
        k.selctl = 1'b1; k.sel = {idx, 2'b00}; k.m = 1'b1; k.s = 4'b1111; k.abus = 1'b1;
        step(k);
    endtask

    function automatic ctrl_t rand_ctrl();
        ctrl_t k = nop();
        k.clr = ($urandom_range(0, 99) == 0);  k.start = ($urandom_range(0, 3) == 0);
        k.selctl = 1'($urandom); k.drw = 1'($urandom); k.lpc = ($urandom_range(0, 3) == 0);
        k.pcinc = 1'($urandom); k.pcadd = ($urandom_range(0, 3) == 0); k.lar = ($urandom_range(0, 3) == 0);
        k.arinc = 1'($urandom); k.lir = ($urandom_range(0, 3) == 0); k.ldz = 1'($urandom);
        k.ldc = 1'($urandom); k.cin = 1'($urandom); k.m = 1'($urandom); k.memw = ($urandom_range(0, 3) == 0);
        k.abus = ($urandom_range(0, 2) == 0); k.sbus = ($urandom_range(0, 2) == 0);
        k.mbus = ($urandom_range(0, 2) == 0); k.stop = ($urandom_range(0, 15) == 0);
        k.sht = ($urandom_range(0, 3) == 0); k.lng = 1'($urandom);
        k.sd = 8'($urandom); k.s = 4'($urandom); k.sel = 4'($urandom);
        return k;
    endfunction

    // Monitor: every cycle with an outstanding expectation is scored after the edge.
    always begin
        @(posedge T3);
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            mon_a.w = int'(W); mon_a.run = int'(RUN); mon_a.pc = int'(PC); mon_a.ar = int'(AR);
            mon_a.ir = int'(IR); mon_a.c = int'(C); mon_a.z = int'(Z);
            mon_a.dbus = int'(DBUS); mon_a.err = int'(BUS_ERR);
            n_checks++;
            if (mon_a.w == mon_e.w && mon_a.run == mon_e.run && mon_a.pc == mon_e.pc && mon_a.ar == mon_e.ar &&
                mon_a.ir == mon_e.ir && mon_a.c == mon_e.c && mon_a.z == mon_e.z) n_pass++;
            else $display("FAIL state @%0t: got W=%0h RUN=%0d PC=%02h AR=%02h IR=%02h C=%0d Z=%0d expected W=%0h RUN=%0d PC=%02h AR=%02h IR=%02h C=%0d Z=%0d",
                          $time, mon_a.w, mon_a.run, mon_a.pc, mon_a.ar, mon_a.ir, mon_a.c, mon_a.z,
                          mon_e.w, mon_e.run, mon_e.pc, mon_e.ar, mon_e.ir, mon_e.c, mon_e.z);
            n_checks++;
            if (mon_a.dbus == mon_e.dbus && mon_a.err == mon_e.err) n_pass++;
            else $display("FAIL bus @%0t: got DBUS=%02h BUS_ERR=%0d expected DBUS=%02h BUS_ERR=%0d",
                          $time, mon_a.dbus, mon_a.err, mon_e.dbus, mon_e.err);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        ctrl_t k;
        k = nop(); k.clr = 1'b1;
        drive(k);
        for (int i = 0; i < 4; i++) m_r[i] = 0;
        for (int i = 0; i < 256; i++) m_mem[i] = 0;

        step(k); settle();
        spot("rst_w", int'(W), 1); spot("rst_run", int'(RUN), 0); spot("rst_pc", int'(PC), int'(RST_PC));
        spot("rst_cz", int'({C, Z}), 0); spot("rst_ir_ar", int'({IR, AR}), 0);

        k = nop(); k.start = 1'b1; k.sbus = 1'b1; k.lpc = 1'b1; k.sd = 8'h99;
        step(k); settle();
        spot("start_run", int'(RUN), 1); spot("start_no_exec", int'(PC), int'(RST_PC));

        con(0, 1, 0, 0, 4'h0, 8'h00);
        for (int i = 0; i < 256; i++) begin
            k = nop(); k.sbus = 1'b1; k.memw = 1'b1; k.arinc = 1'b1; k.sd = 8'($urandom);
            step(k);
        end
        settle(); spot("ar_wrap", int'(AR), 0);

        con(0, 1, 0, 0, 4'h0, 8'h20);
        k = nop(); k.sbus = 1'b1; k.memw = 1'b1; k.arinc = 1'b1; k.sd = 8'hA5;
        step(k); settle(); spot("console_ar", int'(AR), 8'h21);
        con(0, 1, 0, 0, 4'h0, 8'h20);
        k = nop(); k.sbus = 1'b1; k.mbus = 1'b1; k.sd = 8'h5A;
        step(k); settle();
        spot("mbus_prio", int'(DBUS), 8'hA5); spot("bus_err", int'(BUS_ERR), 1);

        con(0, 0, 1, 0, 4'b0100, 8'hFF);
        con(0, 0, 1, 0, 4'b1000, 8'h01);
        load_ir(8'h16); settle(); spot("ir_load", int'(IR), 8'h16);
        k = nop(); k.sht = 1'b0;
        step(k); settle(); spot("w2_entry", int'(W), 2);
        k = nop(); k.s = 4'b1001; k.m = 1'b0; k.cin = 1'b1; k.abus = 1'b1; k.drw = 1'b1; k.ldc = 1'b1; k.ldz = 1'b1;
        step(k); settle(); spot("add_cz", int'({C, Z}), 3);
        read_reg(2'd1); settle(); spot("add_r1", int'(DBUS), 8'h00);

        con(0, 0, 1, 0, 4'b0000, 8'h05);
        con(0, 0, 1, 0, 4'b0100, 8'h05);
        k = nop(); k.selctl = 1'b1; k.sel = 4'b0001; k.s = 4'b0110; k.m = 1'b0; k.cin = 1'b0; k.ldc = 1'b1; k.ldz = 1'b1;
        step(k); settle(); spot("sub_eq_cz", int'({C, Z}), 3);
        read_reg(2'd0); settle(); spot("sub_r0_kept", int'(DBUS), 8'h05);
        con(0, 0, 1, 0, 4'b0000, 8'h03);
        step(k); settle(); spot("sub_borrow_cz", int'({C, Z}), 0);

        load_ir(8'h8E);
        con(1, 0, 0, 0, 4'h0, 8'h10);
        k = nop(); k.pcadd = 1'b1;
        step(k); settle(); spot("pcadd_neg", int'(PC), 8'h0E);
        con(1, 0, 0, 0, 4'h0, 8'hFF);
        k = nop(); k.pcinc = 1'b1;
        step(k); settle(); spot("pc_wrap", int'(PC), 8'h00);
        con(1, 0, 0, 0, 4'h0, 8'hF0);
        k = nop(); k.lir = 1'b1; k.pcinc = 1'b1;
        step(k); settle(); spot("lir_pcinc_ir", int'(IR), 8'h8E); spot("lir_pcinc_pc", int'(PC), 8'hF1);
        k = nop(); k.sbus = 1'b1; k.sd = 8'h33; k.lpc = 1'b1; k.pcadd = 1'b1; k.pcinc = 1'b1;
        step(k); settle(); spot("lpc_prio", int'(PC), 8'h33);

        con(1, 0, 0, 0, 4'h0, 8'h55);
        k = nop(); k.sht = 1'b0; k.lng = 1'b1;
        step(k); settle(); spot("beat_w2", int'(W), 2);
        step(k); settle(); spot("beat_w3", int'(W), 4);
        step(k); settle(); spot("beat_w1", int'(W), 1);
        k = nop();
        step(k); settle(); spot("beat_short", int'(W), 1);
        k = nop(); k.sht = 1'b0;
        step(k);
        k = nop(); k.stop = 1'b1;
        step(k); settle(); spot("stop_run", int'(RUN), 0); spot("stop_w", int'(W), 1);
        k = nop(); k.sbus = 1'b1; k.lpc = 1'b1; k.sd = 8'h77;
        step(k); settle(); spot("halt_no_write", int'(PC), 8'h55);

        k = nop(); k.start = 1'b1;
        step(k);
        con(0, 0, 1, 0, 4'b1000, 8'hFF);
        k = nop(); k.selctl = 1'b1; k.sel = 4'b1000; k.m = 1'b0; k.s = 4'b0000; k.cin = 1'b0; k.ldc = 1'b1; k.ldz = 1'b1;
        step(k); settle(); spot("inc_carry", int'({C, Z}), 3);
        k = nop(); k.sht = 1'b0;
        step(k);
        k = nop(); k.clr = 1'b1; k.lng = 1'b1; k.start = 1'b1;
        step(k); settle();
        spot("clr_mid_w", int'(W), 1); spot("clr_mid_run", int'(RUN), 0);
        spot("clr_mid_pc", int'(PC), int'(RST_PC)); spot("clr_mid_cz", int'({C, Z}), 0);

        k = nop(); k.start = 1'b1;
        step(k);
        for (int i = 0; i < 2000; i++) step(rand_ctrl());

        repeat (3) @(posedge T3);
        #2;
        spot("scoreboard_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
